// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared definitions for the pipeline hazard controller
// Scoreboard entry layout (LSB first): is_load, we, rd[REG_ADDR_W], valid.
package pipe_hazard_ctrl_pkg;

  localparam int FWD_SEL_REGFILE = 0;

  localparam int SB_LOAD_BIT = 0;
  localparam int SB_WE_BIT   = 1;
  localparam int SB_RD_LSB   = 2;
  localparam int SB_CTRL_W   = 3;

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_LOAD_USE,
    MODE_REDIRECT,
    MODE_FREEZE
  } hz_mode_e;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int sb_valid_bit(input int reg_addr_w);
    return SB_RD_LSB + reg_addr_w;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// rtl/pipe_hazard_ctrl_sb_match.sv - one source operand against every scoreboard entry
// Produces the youngest-match forwarding select and the load-use hazard bit.
module sb_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int  REG_ADDR_W   = 5,
  parameter int  FWD_DEPTH    = 3,
  parameter int  LOAD_USE_GAP = 1,
  localparam int SEL_W        = sel_width(FWD_DEPTH),
  localparam int SB_W         = REG_ADDR_W + SB_CTRL_W
) (
  input  logic [REG_ADDR_W-1:0]           rs_i,
  input  logic                            rs_used_i,
  input  logic [FWD_DEPTH-1:0][SB_W-1:0]  sb_i,
  output logic [SEL_W-1:0]                sel_o,
  output logic                            load_use_o
);

  localparam int SB_VALID_BIT = sb_valid_bit(REG_ADDR_W);

  logic [FWD_DEPTH-1:0] hit;

  // x0 is hardwired to zero, so it never matches a producer.
  always_comb begin
    for (int i = 0; i < FWD_DEPTH; i++) begin
      hit[i] = rs_used_i && (rs_i != '0) && sb_i[i][SB_VALID_BIT] && sb_i[i][SB_WE_BIT] &&
               (sb_i[i][SB_RD_LSB +: REG_ADDR_W] == rs_i);
    end
  end

  always_comb begin
    sel_o      = SEL_W'(FWD_SEL_REGFILE);
    load_use_o = 1'b0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (hit[i]) sel_o = SEL_W'(i + 1);
    end
    for (int i = 0; i < LOAD_USE_GAP; i++) begin
      if (hit[i] && sb_i[i][SB_LOAD_BIT]) load_use_o = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - scoreboard-based forwarding, load-use stall, redirect flush, cache freeze
// Optional load-use / redirect performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int  REG_ADDR_W   = 5,
  parameter int  FWD_DEPTH    = 3,
  parameter int  LOAD_USE_GAP = 1,
  parameter int  FLUSH_DEPTH  = 2,
  parameter int  CNT_W        = 32,
  localparam int SEL_W        = sel_width(FWD_DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   id_valid_i,
  input  logic [REG_ADDR_W-1:0]  id_rs1_i,
  input  logic [REG_ADDR_W-1:0]  id_rs2_i,
  input  logic                   id_rs1_used_i,
  input  logic                   id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0]  id_rd_i,
  input  logic                   id_reg_we_i,
  input  logic                   id_is_load_i,
  input  logic                   ex_redirect_i,
  input  logic                   dcache_busy_i,
  input  logic                   icache_busy_i,
  output logic                   pipe_freeze_o,
  output logic                   stall_fe_o,
  output logic                   bubble_ex_o,
  output logic [FLUSH_DEPTH-1:0] flush_mask_o,
  output logic [SEL_W-1:0]       fwd_sel_rs1_o,
  output logic [SEL_W-1:0]       fwd_sel_rs2_o,
  output logic [CNT_W-1:0]       perf_stall_cnt_o,
  output logic [CNT_W-1:0]       perf_flush_cnt_o
);

  localparam int SB_W         = REG_ADDR_W + SB_CTRL_W;
  localparam int SB_VALID_BIT = sb_valid_bit(REG_ADDR_W);

  logic [FWD_DEPTH-1:0][SB_W-1:0] sb_q, sb_d;
  logic [SEL_W-1:0]               sel_rs1_q, sel_rs1_d, sel_rs2_q, sel_rs2_d;
  logic [SEL_W-1:0]               match_sel_rs1, match_sel_rs2;
  logic                           lu_rs1, lu_rs2;
  logic                           redir_pend_q, redir_pend_d;
  logic [SB_W-1:0]                id_entry;
  hz_mode_e                       mode;

  sb_match #(
    .REG_ADDR_W   (REG_ADDR_W),
    .FWD_DEPTH    (FWD_DEPTH),
    .LOAD_USE_GAP (LOAD_USE_GAP)
  ) u_match_rs1 (
    .rs_i       (id_rs1_i),
    .rs_used_i  (id_rs1_used_i),
    .sb_i       (sb_q),
    .sel_o      (match_sel_rs1),
    .load_use_o (lu_rs1)
  );

  sb_match #(
    .REG_ADDR_W   (REG_ADDR_W),
    .FWD_DEPTH    (FWD_DEPTH),
    .LOAD_USE_GAP (LOAD_USE_GAP)
  ) u_match_rs2 (
    .rs_i       (id_rs2_i),
    .rs_used_i  (id_rs2_used_i),
    .sb_i       (sb_q),
    .sel_o      (match_sel_rs2),
    .load_use_o (lu_rs2)
  );

  always_comb begin
    id_entry                              = '0;
    id_entry[SB_VALID_BIT]                = id_valid_i;
    id_entry[SB_WE_BIT]                   = id_reg_we_i;
    id_entry[SB_LOAD_BIT]                 = id_is_load_i;
    id_entry[SB_RD_LSB +: REG_ADDR_W]     = id_rd_i;
  end

  // A redirect seen while frozen is remembered so it still fires once the caches release.
  always_comb begin
    mode = MODE_NORMAL;
    if (dcache_busy_i || icache_busy_i)              mode = MODE_FREEZE;
    else if (ex_redirect_i || redir_pend_q)          mode = MODE_REDIRECT;
    else if (id_valid_i && (lu_rs1 || lu_rs2))       mode = MODE_LOAD_USE;
  end

  assign pipe_freeze_o = (mode == MODE_FREEZE);
  assign stall_fe_o    = (mode == MODE_LOAD_USE);
  assign bubble_ex_o   = (mode == MODE_LOAD_USE) || (mode == MODE_REDIRECT);
  assign flush_mask_o  = (mode == MODE_REDIRECT) ? {FLUSH_DEPTH{1'b1}} : '0;
  assign fwd_sel_rs1_o = sel_rs1_q;
  assign fwd_sel_rs2_o = sel_rs2_q;

  always_comb begin
    sb_d         = sb_q;
    sel_rs1_d    = sel_rs1_q;
    sel_rs2_d    = sel_rs2_q;
    redir_pend_d = redir_pend_q || ex_redirect_i;
    if (mode != MODE_FREEZE) begin
      redir_pend_d = 1'b0;
      for (int i = FWD_DEPTH - 1; i > 0; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      sb_d[0]   = (mode == MODE_NORMAL) ? id_entry : '0;
      sel_rs1_d = (mode == MODE_NORMAL) ? match_sel_rs1 : SEL_W'(FWD_SEL_REGFILE);
      sel_rs2_d = (mode == MODE_NORMAL) ? match_sel_rs2 : SEL_W'(FWD_SEL_REGFILE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sb_q         <= '0;
      sel_rs1_q    <= SEL_W'(FWD_SEL_REGFILE);
      sel_rs2_q    <= SEL_W'(FWD_SEL_REGFILE);
      redir_pend_q <= 1'b0;
    end else begin
      sb_q         <= sb_d;
      sel_rs1_q    <= sel_rs1_d;
      sel_rs2_q    <= sel_rs2_d;
      redir_pend_q <= redir_pend_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(mode == MODE_LOAD_USE);
    flush_cnt_d = flush_cnt_q + CNT_W'(mode == MODE_REDIRECT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector-table bench for pipe_hazard_ctrl
// Each row drives one cycle; its expected fwd_sel pair is queued and checked the following cycle.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       redir;
    logic       db;
    logic       ib;
    logic       chk;
    logic       frz;
    logic       stl;
    logic       bub;
    logic [1:0] fl;
    logic [1:0] s1;
    logic [1:0] s2;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        id_valid, id_rs1_used, id_rs2_used, id_reg_we, id_is_load;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_redirect, dcache_busy, icache_busy;
  logic        pipe_freeze, stall_fe, bubble_ex;
  logic [1:0]  flush_mask, fwd_sel_rs1, fwd_sel_rs2;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  int          n_chk  = 0;
  int          n_fail = 0;
  vec_t        vecs[$];
  logic [3:0]  exp_q[$];

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .id_valid_i       (id_valid),
    .id_rs1_i         (id_rs1),
    .id_rs2_i         (id_rs2),
    .id_rs1_used_i    (id_rs1_used),
    .id_rs2_used_i    (id_rs2_used),
    .id_rd_i          (id_rd),
    .id_reg_we_i      (id_reg_we),
    .id_is_load_i     (id_is_load),
    .ex_redirect_i    (ex_redirect),
    .dcache_busy_i    (dcache_busy),
    .icache_busy_i    (icache_busy),
    .pipe_freeze_o    (pipe_freeze),
    .stall_fe_o       (stall_fe),
    .bubble_ex_o      (bubble_ex),
    .flush_mask_o     (flush_mask),
    .fwd_sel_rs1_o    (fwd_sel_rs1),
    .fwd_sel_rs2_o    (fwd_sel_rs2),
    .perf_stall_cnt_o (perf_stall_cnt),
    .perf_flush_cnt_o (perf_flush_cnt)
  );

  function automatic vec_t mk(input logic rst, input logic vld, input logic [4:0] rs1,
                              input logic u1, input logic [4:0] rs2, input logic u2,
                              input logic [4:0] rd, input logic we, input logic ld,
                              input logic redir, input logic db, input logic ib, input logic chk,
                              input logic frz, input logic stl, input logic bub,
                              input logic [1:0] fl, input logic [1:0] s1, input logic [1:0] s2);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.we = we; v.ld = ld; v.redir = redir; v.db = db; v.ib = ib;
    v.chk = chk; v.frz = frz; v.stl = stl; v.bub = bub; v.fl = fl; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic apply(input int row, input vec_t v);
    logic [3:0] e;
    RESET = v.rst; id_valid = v.vld; id_rs1 = v.rs1; id_rs1_used = v.u1;
    id_rs2 = v.rs2; id_rs2_used = v.u2; id_rd = v.rd; id_reg_we = v.we; id_is_load = v.ld;
    ex_redirect = v.redir; dcache_busy = v.db; icache_busy = v.ib;
    @(negedge CLK);
    if (v.chk) begin
      check("pipe_freeze", row, 32'(pipe_freeze), 32'(v.frz));
      check("stall_fe",    row, 32'(stall_fe),    32'(v.stl));
      check("bubble_ex",   row, 32'(bubble_ex),   32'(v.bub));
      check("flush_mask",  row, 32'(flush_mask),  32'(v.fl));
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fwd_sel_rs1", row, 32'(fwd_sel_rs1), 32'(e[3:2]));
      check("fwd_sel_rs2", row, 32'(fwd_sel_rs2), 32'(e[1:0]));
    end
    exp_q.push_back({v.s1, v.s2});
    @(posedge CLK);
    #1;
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
    vecs.delete();
  endtask

  initial begin
    // reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    // addi x5 ; add x6,x5,x5
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 5, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 5, 1, 5, 1, 6, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0,  1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    // lw x7 ; add x8,x7,x0 -> one stall then sel 2
    vecs.push_back(mk(0, 1, 2, 1, 0, 0, 7, 1, 1,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 7, 1, 0, 1, 8, 1, 0,  0, 0, 0, 1,  0, 1, 1, 0,  0, 0));
    vecs.push_back(mk(0, 1, 7, 1, 0, 1, 8, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0,  2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    // lw x10 ; redirect while dependent add sits in ID
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 10, 1, 10, 1, 11, 1, 0, 1, 0, 0, 1, 0, 0, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    // forward from x13, then redirect held off by 3 cycles of dcache_busy
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 13, 1, 0, 1, 14, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0));
    vecs.push_back(mk(0, 1, 14, 1, 0, 0, 15, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0,  1, 0));
    vecs.push_back(mk(0, 1, 14, 1, 0, 0, 15, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0,  1, 0));
    vecs.push_back(mk(0, 1, 14, 1, 0, 0, 15, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0,  1, 0));
    vecs.push_back(mk(0, 1, 14, 1, 0, 0, 15, 1, 0, 0, 0, 0, 1, 0, 0, 1, 3,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1,  1, 0, 0, 0,  0, 0));
    // x0 never forwards; x9 in entries 0 and 2 -> youngest wins
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 9, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 9, 1, 9, 1, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    // load-use through rs2
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 18, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 18, 1, 19, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 18, 1, 19, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 2));
    // reset in the middle of a load-use stall
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(1, 1, 16, 1, 0, 0, 17, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0,  0, 0));
    vecs.push_back(mk(0, 1, 16, 1, 0, 0, 17, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    run_table();

`ifdef PIPE_PERF_CNT_EN
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 20, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 20, 1, 0, 0, 21, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 20, 1, 0, 0, 21, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0));
    end
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 20, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 20, 1, 0, 0, 21, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 3, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    end
    run_table();
    check("perf_stall_cnt", -1, perf_stall_cnt, 32'd4);
    check("perf_flush_cnt", -1, perf_flush_cnt, 32'd2);
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
    run_table();
    check("perf_stall_cnt_rst", -1, perf_stall_cnt, 32'd0);
    check("perf_flush_cnt_rst", -1, perf_flush_cnt, 32'd0);
`else
    check("perf_stall_cnt_tied", -1, perf_stall_cnt, 32'd0);
    check("perf_flush_cnt_tied", -1, perf_flush_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
